// File: rtl/id_bundle_queue.sv
// Decode-to-dispatch bundle queue: valid/ready FIFO of LANES-wide decoded bundles
// with bubble squashing, synchronous kill, occupancy status and optional empty bypass.
module id_bundle_queue #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned BYPASS    = 0,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         kill_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [LANES-1:0]             enq_lane_valid_i,
    input  logic [LANES*PAYLOAD_W-1:0]   enq_payload_i,
    output logic                         deq_valid_o,
    input  logic                         deq_ready_i,
    output logic [LANES-1:0]             deq_lane_valid_o,
    output logic [LANES*PAYLOAD_W-1:0]   deq_payload_o,
    output logic [CNT_W-1:0]             count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned DATA_W = LANES * PAYLOAD_W;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] pay_mem  [DEPTH];
    logic [LANES-1:0]  mask_mem [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic full_c;
    logic empty_c;
    logic bubble_c;
    logic byp_c;
    logic enq_fire_c;
    logic deq_valid_c;
    logic deq_fire_c;
    logic push_c;
    logic pop_c;

    // Handshake and occupancy decode, all derived from registered state plus inputs
    always_comb begin
        full_c      = (count_q == CNT_W'(DEPTH));
        empty_c     = (count_q == '0);
        bubble_c    = ~|enq_lane_valid_i;
        // Bypass is held off during reset so the reset output values hold
        byp_c       = BYP_EN & reset_n_i & empty_c & enq_valid_i & ~bubble_c & ~kill_i;
        enq_fire_c  = enq_valid_i & ~full_c & ~bubble_c & ~kill_i;
        deq_valid_c = ~empty_c | byp_c;
        deq_fire_c  = deq_valid_c & deq_ready_i & ~kill_i;
        // A bypassed bundle that is consumed immediately never touches storage
        push_c      = enq_fire_c & ~(byp_c & deq_ready_i);
        pop_c       = deq_fire_c & ~byp_c;
    end

    // Head presentation: bypass path, forced zero when empty, else stored head
    always_comb begin
        deq_valid_o      = deq_valid_c;
        deq_lane_valid_o = '0;
        deq_payload_o    = '0;
        if (byp_c) begin
            deq_lane_valid_o = enq_lane_valid_i;
            deq_payload_o    = enq_payload_i;
        end else if (!empty_c) begin
            deq_lane_valid_o = mask_mem[head_q];
            deq_payload_o    = pay_mem[head_q];
        end
    end

    assign enq_ready_o = ~full_c;
    assign count_o     = count_q;
    assign full_o      = full_c;
    assign empty_o     = empty_c;

    // Pointers, occupancy and lane masks
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mask_mem[i] <= '0;
            end
        end else if (kill_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mask_mem[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mask_mem[tail_q] <= enq_lane_valid_i;
                tail_q           <= tail_q + PTR_W'(1);
            end
            if (pop_c) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage is intentionally left without reset
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            pay_mem[tail_q] <= enq_payload_i;
        end
    end

endmodule

// File: doc/id_bundle_queue.md
Name: id_bundle_queue

Overview:
- Parametrised decode-to-dispatch pipeline buffer between the ID decoders and the dispatch stage.
- Holds up to DEPTH decoded bundles, each LANES wide, with PAYLOAD_W bits of decode fields per lane.
- Replaces the single stall/kill pipeline register with a valid/ready queue, bubble squashing, per-lane valid masks, occupancy status and an optional same-cycle bypass mode.

Parameters:
- LANES, 2: decode lanes per bundle (>=1).
- PAYLOAD_W, 64: decoded-field bits per lane (imm type, regs, selects, ALU/MD/mem ops, packed by the ID stage).
- DEPTH, 2: bundle entries; power of two, >=2.
- BYPASS, 0: 1 = empty-queue combinational pass-through from enq to deq.
- CNT_W, $clog2(DEPTH+1): occupancy width (derived, not overridden).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- kill_i  in  1  flush all entries (branch mispredict/exception), synchronous.
- enq_valid_i  in  1  upstream bundle valid.
- enq_ready_o  out  1  queue can accept a bundle this cycle.
- enq_lane_valid_i  in  LANES  per-lane valid mask of the incoming bundle.
- enq_payload_i  in  LANES*PAYLOAD_W  lane i at bits [i*PAYLOAD_W +: PAYLOAD_W].
- deq_valid_o  out  1  head bundle valid.
- deq_ready_i  in  1  dispatch consumes head this cycle.
- deq_lane_valid_o  out  LANES  head lane mask.
- deq_payload_o  out  LANES*PAYLOAD_W  head payload.
- count_o  out  CNT_W  stored bundles (excludes bypassed bundle).
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- State: payload/mask array [DEPTH], head/tail pointers (log2 DEPTH bits, natural wrap), count register. Only pointers, count and mask array are reset. Payload array is not reset.
- Reset (reset_n_i low, asynchronous): count=0, pointers=0, masks=0.
  - Outputs during reset: enq_ready_o=1, deq_valid_o=0, deq_lane_valid_o=0, deq_payload_o=0, count_o=0, full_o=0, empty_o=1.
- enq fire = enq_valid_i & enq_ready_o & |enq_lane_valid_i & ~kill_i.
  - A bundle with an all-zero mask is a bubble. It is squashed: never stored, never counted, never presented.
- deq fire = deq_valid_o & deq_ready_i & ~kill_i.
- enq_ready_o = ~full_o. It is purely registered-state derived. A full queue does not accept even when a deq fires the same cycle.
- Latency (BYPASS=0): a bundle enqueued at edge k is at deq outputs after edge k; minimum 1 cycle. Throughput 1 bundle/cycle with simultaneous enq+deq, count unchanged.
- Head outputs: deq_valid_o = ~empty_o. When empty, deq_lane_valid_o and deq_payload_o are forced to 0. When not empty, they are the head entry.
- count update: +1 on enq only, -1 on deq only, unchanged on both or neither. Pointers advance modulo DEPTH on their own fire.
- kill_i (edge where high): count=0, head=tail=0, masks cleared. Same-cycle enq and deq are ignored. Outputs show empty from the next cycle.
  - deq_valid_o is still driven from current state during the kill cycle. Dispatch must gate with kill itself.
- BYPASS=1, queue empty, enq_valid_i & |enq_lane_valid_i & ~kill_i:
  - deq_valid_o=1; deq outputs = enq inputs combinationally.
  - If deq_ready_i: bundle consumed, not stored, count stays 0.
  - Else: stored normally, presented from storage next cycle.
  - Never bypass while non-empty (ordering preserved).
  - kill_i forces deq_valid_o=0 in bypass.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Assertions (bench): count_o <= DEPTH; no enq fire when full_o; no deq fire when empty (BYPASS=0).

Test Plan:
1. Reset then idle (DEPTH=2, LANES=2) -> enq_ready_o=1, empty_o=1, deq_valid_o=0, deq_payload_o=0, count_o=0.
2. Enq A (mask 2'b11), B (2'b01), C with deq_ready_i=0 -> count 1,2; full_o=1 after B; C held off (enq_ready_o=0); then deq_ready_i=1 -> A then B out in order, mask 2'b01 on B, count back to 0.
3. Enq bundle with mask 2'b00 every cycle, 4 cycles -> count_o stays 0, deq_valid_o stays 0.
4. Queue holding 2 bundles, kill_i pulse coinciding with enq_valid_i=1 and deq_ready_i=1 -> next cycle count_o=0, empty_o=1; the killed enq never appears.
5. DEPTH=4, 10 back-to-back enq with deq_ready_i=1 continuous -> steady count_o=1, outputs in order, pointers wrap without loss.
6. BYPASS=1, empty, enq X with deq_ready_i=1 -> same-cycle deq_valid_o=1, deq_payload_o=X, count_o stays 0. Repeat with deq_ready_i=0 -> count_o=1, X presented from storage next cycle.
